// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register addresses and the widest supported port.
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;

    localparam logic [2:0] GPIO_ADDR_OUT  = 3'd0;
    localparam logic [2:0] GPIO_ADDR_DIR  = 3'd1;
    localparam logic [2:0] GPIO_ADDR_IN   = 3'd2;
    localparam logic [2:0] GPIO_ADDR_IE   = 3'd3;
    localparam logic [2:0] GPIO_ADDR_EDGE = 3'd4;
    localparam logic [2:0] GPIO_ADDR_STAT = 3'd5;
    localparam logic [2:0] GPIO_ADDR_SET  = 3'd6;
    localparam logic [2:0] GPIO_ADDR_CLR  = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain that brings asynchronous pad inputs into the clk domain.
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO block: output/direction registers, atomic set/clear,
// synchronised inputs and per-bit edge interrupts with write-1-to-clear status.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_ie;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_clr_mask;
    logic [WIDTH-1:0] w_stat_next;
    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] w_rdata_next;
    logic             w_irq_next;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin_in),
        .q     (w_sync)
    );

    // Per-bit edge selection: EDGE=1 picks the rising edge, EDGE=0 the falling one.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
        logic w_rise;
        logic w_fall;
        assign w_rise    = w_sync[gi] & ~r_prev[gi];
        assign w_fall    = ~w_sync[gi] & r_prev[gi];
        assign w_evt[gi] = r_edge[gi] ? w_rise : w_fall;
    end

    assign w_clr_mask  = (we && addr == GPIO_ADDR_STAT) ? wdata : '0;
    // OR-ing the new events in last lets a fresh event win over a same-cycle clear.
    assign w_stat_next = (r_stat & ~w_clr_mask) | (w_evt & r_ie);
    assign w_irq_next  = |(w_stat_next & r_ie);

    always_comb begin
        w_out_next = r_out;
        if (we) begin
            case (addr)
                GPIO_ADDR_OUT: w_out_next = wdata;
                GPIO_ADDR_SET: w_out_next = r_out | wdata;
                GPIO_ADDR_CLR: w_out_next = r_out & ~wdata;
                default:       w_out_next = r_out;
            endcase
        end
    end

    always_comb begin
        w_rdata_next = '0;
        case (addr)
            GPIO_ADDR_OUT:  w_rdata_next = r_out;
            GPIO_ADDR_DIR:  w_rdata_next = r_dir;
            GPIO_ADDR_IN:   w_rdata_next = w_sync;
            GPIO_ADDR_IE:   w_rdata_next = r_ie;
            GPIO_ADDR_EDGE: w_rdata_next = r_edge;
            GPIO_ADDR_STAT: w_rdata_next = r_stat;
            default:        w_rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_ie    <= '0;
            r_edge  <= '0;
            r_stat  <= '0;
            r_prev  <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_out   <= w_out_next;
            r_stat  <= w_stat_next;
            r_prev  <= w_sync;
            r_rdata <= w_rdata_next;
            r_irq   <= w_irq_next;
            if (we && addr == GPIO_ADDR_DIR) begin
                r_dir <= wdata;
            end
            if (we && addr == GPIO_ADDR_IE) begin
                r_ie <= wdata;
            end
            if (we && addr == GPIO_ADDR_EDGE) begin
                r_edge <= wdata;
            end
        end
    end

    assign rdata   = r_rdata;
    assign pin_out = r_out;
    assign pin_oe  = r_dir;
    assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: stimulus pushes timed expectations, a negedge monitor checks them.
module tb_gpio_ctrl;

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_OE  = 2;
    localparam int K_IRQ = 3;

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_IE   = 3'd3;
    localparam logic [2:0] A_EDGE = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pin_in;
    logic [31:0] pin_out;
    logic [31:0] pin_oe;
    logic        irq;

    int        cyc;
    int        checks;
    int        errors;
    sb_entry_t sb[$];

    gpio_ctrl #(
        .WIDTH       (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int kind, input logic [31:0] exp, input int dly, input string name);
        sb_entry_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input logic w, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RD:    return rdata;
            K_OUT:   return pin_out;
            K_OE:    return pin_oe;
            default: return {31'd0, irq};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [31:0] act;
                act = observe(sb[i].kind);
                checks++;
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
                end else begin
                    $display("ok   %s: 0x%08h (cycle %0d)", sb[i].name, act, cyc);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        addr   = 3'd0;
        wdata  = 32'd0;
        pin_in = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        expect_at(K_OUT, 32'h0, 0, "rst_pin_out");
        expect_at(K_OE,  32'h0, 0, "rst_pin_oe");
        expect_at(K_IRQ, 32'h0, 0, "rst_irq");
        expect_at(K_RD,  32'h0, 0, "rst_rdata");
        @(negedge clk);
        rst_n = 1'b1;

        // Output register, atomic set/clear, read-back
        step(1'b1, A_OUT, 32'h0000_00F0); expect_at(K_OUT, 32'h0000_00F0, 1, "out_write");
        step(1'b1, A_SET, 32'h0000_000F); expect_at(K_OUT, 32'h0000_00FF, 1, "out_set");
        step(1'b1, A_CLR, 32'h0000_0030); expect_at(K_OUT, 32'h0000_00CF, 1, "out_clr");
        step(1'b0, A_OUT, 32'h0);         expect_at(K_RD,  32'h0000_00CF, 1, "rd_out");
        step(1'b0, A_SET, 32'h0);         expect_at(K_RD,  32'h0, 1, "rd_set_zero");
        step(1'b0, A_CLR, 32'h0);         expect_at(K_RD,  32'h0, 1, "rd_clr_zero");

        // Direction write, same-cycle read shows pre-write value
        step(1'b1, A_DIR, 32'hFFFF_0000);
        expect_at(K_OE,  32'hFFFF_0000, 1, "dir_oe");
        expect_at(K_RD,  32'h0, 1, "rd_dir_prewrite");
        expect_at(K_OUT, 32'h0000_00CF, 1, "out_hold");
        step(1'b0, A_DIR, 32'h0);         expect_at(K_RD, 32'hFFFF_0000, 1, "rd_dir");

        // Input synchroniser latency: IN read-back appears 3 cycles after the pin change
        step(1'b0, A_IN, 32'h0); pin_in = 32'h5; expect_at(K_RD, 32'h0, 1, "in_lat1");
        step(1'b0, A_IN, 32'h0); expect_at(K_RD, 32'h0, 1, "in_lat2");
        step(1'b0, A_IN, 32'h0); expect_at(K_RD, 32'h5, 1, "in_lat3");
        step(1'b1, A_IN, 32'hFFFF_FFFF); pin_in = 32'h0;
        step(1'b0, A_IN, 32'h0); expect_at(K_RD, 32'h5, 1, "in_write_ignored");
        repeat (4) step(1'b0, A_OUT, 32'h0);

        // Rising-edge interrupt on bit 0
        step(1'b1, A_IE, 32'h1);
        step(1'b1, A_EDGE, 32'h1);
        step(1'b0, A_STAT, 32'h0); expect_at(K_RD, 32'h0, 1, "stat_idle");
        step(1'b0, A_STAT, 32'h0); pin_in = 32'h1;
        expect_at(K_IRQ, 32'h0, 2, "irq_not_early");
        expect_at(K_IRQ, 32'h1, 3, "irq_rise");
        step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0); expect_at(K_RD, 32'h1, 1, "stat_rise");
        step(1'b1, A_STAT, 32'h1);
        expect_at(K_IRQ, 32'h0, 1, "irq_w1c");
        expect_at(K_RD,  32'h1, 1, "stat_prewrite");
        step(1'b0, A_STAT, 32'h0); expect_at(K_RD, 32'h0, 1, "stat_cleared");

        // Falling edge with EDGE=1 raises nothing
        step(1'b0, A_STAT, 32'h0); pin_in = 32'h0;
        repeat (4) step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0);
        expect_at(K_RD,  32'h0, 1, "stat_no_fall");
        expect_at(K_IRQ, 32'h0, 1, "irq_no_fall");

        // Falling-edge interrupt on bit 2, then W1C colliding with a new event
        step(1'b1, A_EDGE, 32'h0);
        step(1'b1, A_IE, 32'h4);
        step(1'b0, A_STAT, 32'h0); pin_in = 32'h4;
        repeat (4) step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0); expect_at(K_RD, 32'h0, 1, "stat_no_rise_b2");
        step(1'b0, A_STAT, 32'h0); pin_in = 32'h0;
        expect_at(K_IRQ, 32'h1, 3, "irq_fall_b2");
        step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0); expect_at(K_RD, 32'h4, 1, "stat_fall_b2");
        step(1'b0, A_STAT, 32'h0); pin_in = 32'h4;
        repeat (4) step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0); pin_in = 32'h0;
        step(1'b0, A_STAT, 32'h0);
        step(1'b1, A_STAT, 32'h4);
        expect_at(K_RD,  32'h4, 1, "stat_coll_prewrite");
        expect_at(K_IRQ, 32'h1, 1, "irq_coll");
        step(1'b0, A_STAT, 32'h0);
        expect_at(K_RD,  32'h4, 1, "stat_coll");
        expect_at(K_IRQ, 32'h1, 1, "irq_coll_hold");

        // Masking IE drops irq but keeps the status bit
        step(1'b1, A_IE, 32'h0); expect_at(K_IRQ, 32'h0, 2, "irq_masked");
        step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0); expect_at(K_RD, 32'h4, 1, "stat_kept_masked");

        // Asynchronous reset mid-traffic with all pins high
        pin_in = 32'hFFFF_FFFF;
        step(1'b0, A_STAT, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expect_at(K_OUT, 32'h0, 0, "arst_pin_out");
        expect_at(K_OE,  32'h0, 0, "arst_pin_oe");
        expect_at(K_IRQ, 32'h0, 0, "arst_irq");
        expect_at(K_RD,  32'h0, 0, "arst_rdata");
        #1;
        checks++;
        if (pin_out !== 32'h0) begin
            errors++;
            $display("FAIL arst_now_pin_out: got 0x%08h expected 0x00000000", pin_out);
        end else begin
            $display("ok   arst_now_pin_out: 0x%08h", pin_out);
        end
        checks++;
        if (pin_oe !== 32'h0) begin
            errors++;
            $display("FAIL arst_now_pin_oe: got 0x%08h expected 0x00000000", pin_oe);
        end else begin
            $display("ok   arst_now_pin_oe: 0x%08h", pin_oe);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL arst_now_irq: got %b expected 0", irq);
        end else begin
            $display("ok   arst_now_irq: %b", irq);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL arst_now_rdata: got 0x%08h expected 0x00000000", rdata);
        end else begin
            $display("ok   arst_now_rdata: 0x%08h", rdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, A_STAT, 32'h0);
        step(1'b0, A_STAT, 32'h0);
        expect_at(K_RD,  32'h0, 1, "stat_after_rst");
        expect_at(K_IRQ, 32'h0, 1, "irq_after_rst");
        step(1'b0, A_IN,  32'h0); expect_at(K_RD, 32'hFFFF_FFFF, 1, "in_after_rst");
        step(1'b0, A_OUT, 32'h0); expect_at(K_RD, 32'h0, 1, "out_after_rst");
        step(1'b0, A_IE,  32'h0); expect_at(K_RD, 32'h0, 1, "ie_after_rst");
        repeat (3) @(negedge clk);
        #1;

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: never checked, expected 0x%08h at cycle %0d", sb[0].name, sb[0].exp, sb[0].due);
            void'(sb.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
